// File: rtl/fp_normalize_pipe.sv
// Post-add/subtract normalization: leading-zero count, left shift, exponent adjust.
// Two registered stages with a valid/ready handshake toward the rounding stage.
module fp_normalize_pipe #(
    parameter  int MANT_W = 24,
    parameter  int EXP_W  = 8,
    localparam int LZ_W   = $clog2(MANT_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [LZ_W-1:0]   out_lz,
    output logic              out_zero,
    output logic              out_denorm
);

    localparam int NSLICE = MANT_W / 8;
    localparam int CW     = (EXP_W > LZ_W) ? EXP_W : LZ_W;

    logic              r_s1_valid;
    logic [MANT_W-1:0] r_s1_mant;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [LZ_W-1:0]   r_s1_lz;

    logic              r_s2_valid;
    logic [MANT_W-1:0] r_s2_mant;
    logic [EXP_W-1:0]  r_s2_exp;
    logic [LZ_W-1:0]   r_s2_lz;
    logic              r_s2_zero;
    logic              r_s2_denorm;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_accept;
    logic              w_move;
    logic [LZ_W-1:0]   w_lz;
    logic [CW-1:0]     w_exp_ext;
    logic [CW-1:0]     w_lz_ext;
    logic [MANT_W-1:0] w_mant;
    logic [EXP_W-1:0]  w_exp;
    logic              w_zero;
    logic              w_denorm;

    // Handshake: a beat transfers on any edge where valid && ready. Each stage
    // advances when it is empty or its successor advances, so emit, S1->S2
    // move and a new accept can all happen on the same edge; ready never
    // depends on valid of the same side.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_accept = in_valid && w_s1_adv;
    assign w_move   = r_s1_valid && w_s2_adv;

    // Leading-zero count of one byte; 8 when the byte is all zero.
    function automatic logic [3:0] clz8(input logic [7:0] b);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) n = 4'(7 - i);
        end
        return n;
    endfunction

    // Byte counters combined MSB-first: a lower byte contributes only while
    // every byte above it was all zero.
    always_comb begin
        logic found;
        found = 1'b0;
        w_lz  = '0;
        for (int s = NSLICE - 1; s >= 0; s--) begin
            if (!found) begin
                w_lz = w_lz + LZ_W'(clz8(in_mant[s*8 +: 8]));
                if (|in_mant[s*8 +: 8]) found = 1'b1;
            end
        end
    end

    assign w_exp_ext = CW'(r_s1_exp);
    assign w_lz_ext  = CW'(r_s1_lz);

    always_comb begin
        logic [LZ_W-1:0] shift;
        shift    = '0;
        w_mant   = '0;
        w_exp    = '0;
        w_zero   = 1'b0;
        w_denorm = 1'b0;
        if (r_s1_lz == LZ_W'(MANT_W)) begin
            w_zero = 1'b1;
        end else if (w_exp_ext > w_lz_ext) begin
            w_mant = r_s1_mant << r_s1_lz;
            w_exp  = EXP_W'(w_exp_ext - w_lz_ext);
        end else begin
            // Exponent runs out first: shift only until the biased exponent
            // reaches the subnormal encoding, which is always < MANT_W here.
            shift    = (r_s1_exp == '0) ? '0 : LZ_W'(w_exp_ext - CW'(1));
            w_mant   = r_s1_mant << shift;
            w_denorm = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_mant   <= '0;
            r_s1_exp    <= '0;
            r_s1_lz     <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_mant   <= '0;
            r_s2_exp    <= '0;
            r_s2_lz     <= '0;
            r_s2_zero   <= 1'b0;
            r_s2_denorm <= 1'b0;
        end else begin
            if (w_s1_adv) r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_mant <= in_mant;
                r_s1_exp  <= in_exp;
                r_s1_lz   <= w_lz;
            end
            if (w_s2_adv) r_s2_valid <= r_s1_valid;
            if (w_move) begin
                r_s2_mant   <= w_mant;
                r_s2_exp    <= w_exp;
                r_s2_lz     <= r_s1_lz;
                r_s2_zero   <= w_zero;
                r_s2_denorm <= w_denorm;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_mant   = r_s2_mant;
    assign out_exp    = r_s2_exp;
    assign out_lz     = r_s2_lz;
    assign out_zero   = r_s2_zero;
    assign out_denorm = r_s2_denorm;

endmodule

// File: doc/fp_normalize_pipe.md
Name: fp_normalize_pipe

Overview:
- Post-add/subtract normalization stage of the FPU. Consumes an unnormalized mantissa and biased exponent, and counts leading zeros with a tree of the existing leading-zero counters.
- Left-shifts the mantissa so its MSB is 1 and adjusts the exponent. Saturates to a subnormal result when the exponent cannot absorb the shift.
- Two-stage valid/ready pipeline feeding the rounding stage.

Parameters:
- MANT_W, 24, mantissa width including hidden bit; must be a multiple of 8, range 8..32.
- EXP_W, 8, biased exponent width.
- LZ_W, $clog2(MANT_W)+1, width of leading-zero count (derived, not overridable).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept input this cycle
- in_mant  input  MANT_W  unnormalized mantissa
- in_exp  input  EXP_W  biased exponent (unsigned)
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts output this cycle
- out_mant  output  MANT_W  normalized mantissa
- out_exp  output  EXP_W  adjusted biased exponent
- out_lz  output  LZ_W  leading-zero count of in_mant (MANT_W when zero)
- out_zero  output  1  input mantissa was all zero
- out_denorm  output  1  result is subnormal (exponent clamped to 0)

Behaviour:
- Stage 1 (S1): on accept (in_valid && in_ready), register in_mant, in_exp, and lz = CLZ(in_mant). lz is built from 8-bit counter slices combined MSB-first, with a lower slice counted only when every higher slice is all-zero.
- Stage 2 (S2): register shift result, exponent, and flags from S1:
  - zero (lz == MANT_W): mant = 0, exp = 0, zero = 1, denorm = 0.
  - in_exp > lz: mant = in_mant << lz, exp = in_exp - lz, denorm = 0.
  - in_exp <= lz, nonzero: shift = (in_exp == 0) ? 0 : in_exp - 1; mant = in_mant << shift; exp = 0; denorm = 1.
  - Compare in_exp and lz zero-extended to max(EXP_W, LZ_W). The shift is always < MANT_W, so there is no overflow.
- Outputs are driven directly from S2 registers. There is no combinational path from inputs to out_* data.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - S1 moves into S2 when s1_valid && s2_adv.
- out_valid = s2_valid. While out_valid && !out_ready, all out_* hold stable.
- Latency: 2 cycles from accept to out_valid when out_ready stays high. Throughput is 1 beat/cycle.
- Full: both stages valid and out_ready low → in_ready = 0. A beat presented then is not accepted and must be held by the producer.
- Simultaneous: S2 emit, S1→S2 move, and new accept all happen in the same cycle with no bubble.
- Ordering: FIFO order preserved. No beat is dropped or duplicated.
- Reset (any time, including mid-stream): next edge clears s1_valid and s2_valid. out_valid = 0 and in_ready = 1 after reset. Data registers and flags reset to 0, so out_mant = 0, out_exp = 0, out_lz = 0, out_zero = 0, out_denorm = 0.
- Reset overrides a concurrent in_valid; that beat is dropped.

Test Plan (MANT_W=24, EXP_W=8):
- in_mant=0x800000, in_exp=127, out_ready=1 → 2 cycles later out_valid=1, out_mant=0x800000, out_exp=127, out_lz=0, flags 0.
- in_mant=0x000001, in_exp=100 → out_mant=0x800000, out_exp=77, out_lz=23, out_denorm=0.
- in_mant=0x000100, in_exp=5 (lz=15) → shift 4, out_mant=0x001000, out_exp=0, out_denorm=1; also in_exp=0 → out_mant unchanged, out_exp=0, out_denorm=1.
- in_mant=0, in_exp=50 → out_zero=1, out_mant=0, out_exp=0, out_lz=24.
- Back-to-back beats A, B, C with out_ready low for 4 cycles after A reaches S2:
  - in_ready=0 once A and B are stored; C is held by the producer.
  - out_* stay equal to A while stalled.
  - After release, A, B, C emerge on consecutive cycles in order.
- Reset asserted for 1 cycle with both stages valid and in_valid=1 → next cycle out_valid=0, in_ready=1, all outputs 0; no stale beat appears afterward.
